// File: rtl/mw_pkg.sv
// rtl/mw_pkg.sv - shared state encoding, defaults and power clamp for the microwave controller
package mw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COOK  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } mw_state_e;

    localparam int DEF_DUTY_WINDOW = 10;
    localparam int DEF_BEEP_SECS   = 3;
    localparam int DEF_MAX_DIGITS  = 4;

    // Out-of-range settings fall back to full power rather than off.
    function automatic logic [3:0] clamp_power(input logic [3:0] level);
        return (level == 4'd0 || level > 4'd10) ? 4'd10 : level;
    endfunction

endpackage

// File: rtl/mw_duty_gen.sv
// rtl/mw_duty_gen.sv - duty-window phase counter and power compare for the magnetron
module mw_duty_gen
    import mw_pkg::*;
#(
    parameter int DUTY_WINDOW = DEF_DUTY_WINDOW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       restart,
    input  logic       tick_1hz,
    input  logic [3:0] eff_power,
    output logic       duty_on
);

    localparam int PW = $clog2(DUTY_WINDOW + 16);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (restart) begin
            phase_d = '0;
        end else if (run && tick_1hz) begin
            phase_d = (phase_q == PW'(DUTY_WINDOW - 1)) ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Compare against the upcoming phase so the registered mag_on lines up with it.
    assign duty_on = phase_d < {{(PW-4){1'b0}}, eff_power};

endmodule

// File: rtl/mw_cook_sequencer.sv
// rtl/mw_cook_sequencer.sv - cook-cycle FSM driving timer strobes, magnetron duty and beep
module mw_cook_sequencer
    import mw_pkg::*;
#(
    parameter int DUTY_WINDOW = DEF_DUTY_WINDOW,
    parameter int BEEP_SECS   = DEF_BEEP_SECS,
    parameter int MAX_DIGITS  = DEF_MAX_DIGITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic [3:0] power_level,
    input  logic       timer_zero,
    output logic       timer_load,
    output logic [3:0] timer_digit,
    output logic       timer_dec,
    output logic       timer_clear,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int BW = $clog2(BEEP_SECS + 1);

    mw_state_e     state_q;
    mw_state_e     state_d;
    logic [CW-1:0] digit_cnt;
    logic [BW-1:0] beep_cnt;
    logic          key_ok;
    logic          dec_d;
    logic          clr_d;
    logic          cnt_clr;
    logic          restart;
    logic          beep_inc;
    logic          run;
    logic          duty_on;
    logic [3:0]    eff_power;

    assign eff_power = clamp_power(power_level);
    assign run       = (state_q == ST_COOK) && (state_d == ST_COOK);
    assign state     = state_q;

    mw_duty_gen #(
        .DUTY_WINDOW(DUTY_WINDOW)
    ) u_duty (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .restart  (restart),
        .tick_1hz (tick_1hz),
        .eff_power(eff_power),
        .duty_on  (duty_on)
    );

    // Each branch chain encodes the input priority: clear, stop/door, timer_zero, start, tick, key.
    always_comb begin
        state_d  = state_q;
        key_ok   = 1'b0;
        dec_d    = 1'b0;
        clr_d    = 1'b0;
        cnt_clr  = 1'b0;
        restart  = 1'b0;
        beep_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    clr_d   = 1'b1;
                    cnt_clr = 1'b1;
                end else if (start && !stop) begin
                    if (door_closed && !timer_zero) begin
                        state_d = ST_COOK;
                        restart = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end else if (!stop && key_valid && key_digit <= 4'd9
                             && digit_cnt < CW'(MAX_DIGITS)) begin
                    key_ok = 1'b1;
                end
            end
            ST_COOK: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (stop || !door_closed) begin
                    state_d = ST_PAUSE;
                end else if (timer_zero) begin
                    state_d = ST_DONE;
                end else if (tick_1hz) begin
                    dec_d = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (clear || stop) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    cnt_clr = 1'b1;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (clear || stop || !door_closed) begin
                    state_d = ST_IDLE;
                    clr_d   = clear;
                end else if (tick_1hz) begin
                    if (beep_cnt == BW'(BEEP_SECS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        beep_inc = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            digit_cnt   <= '0;
            beep_cnt    <= '0;
            timer_load  <= 1'b0;
            timer_digit <= 4'd0;
            timer_dec   <= 1'b0;
            timer_clear <= 1'b0;
            mag_on      <= 1'b0;
            beep        <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_load  <= key_ok;
            timer_dec   <= dec_d;
            timer_clear <= clr_d;
            if (key_ok) begin
                timer_digit <= key_digit;
                digit_cnt   <= digit_cnt + CW'(1);
            end else if (cnt_clr) begin
                digit_cnt <= '0;
            end
            // Door is rechecked here so an opening drops the magnetron within one cycle.
            mag_on <= (state_d == ST_COOK) && door_closed && duty_on;
            beep   <= (state_d == ST_DONE);
            if (state_d != ST_DONE) begin
                beep_cnt <= '0;
            end else if (beep_inc) begin
                beep_cnt <= beep_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mw_cook_sequencer.sv
// tb/tb_mw_cook_sequencer.sv - directed vector bench for mw_cook_sequencer
module tb_mw_cook_sequencer;
    import mw_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [3:0] power_level;
    logic       timer_zero;
    logic       timer_load;
    logic [3:0] timer_digit;
    logic       timer_dec;
    logic       timer_clear;
    logic       mag_on;
    logic       beep;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int dec_seen = 0;

    typedef struct {
        logic       rst, start, stop, clr, door, kv;
        logic [3:0] kd, pwr;
        logic       tz, tick;
        logic       e_load;
        logic [3:0] e_digit;
        logic       e_dec, e_clr, e_mag, e_beep;
        logic [2:0] e_st;
    } vec_t;

    vec_t tbl[$];

    mw_cook_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .door_closed(door_closed),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .power_level(power_level),
        .timer_zero (timer_zero),
        .timer_load (timer_load),
        .timer_digit(timer_digit),
        .timer_dec  (timer_dec),
        .timer_clear(timer_clear),
        .mag_on     (mag_on),
        .beep       (beep),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, input int s, input int p, input int c, input int d,
                                input int kv, input int kd, input int pw, input int tz, input int tk,
                                input int ld, input int dg, input int dec, input int tc,
                                input int mag, input int bp, input int st);
        vec_t v;
        v.rst = 1'(r);      v.start = 1'(s);   v.stop = 1'(p);   v.clr = 1'(c);
        v.door = 1'(d);     v.kv = 1'(kv);     v.kd = 4'(kd);    v.pwr = 4'(pw);
        v.tz = 1'(tz);      v.tick = 1'(tk);
        v.e_load = 1'(ld);  v.e_digit = 4'(dg); v.e_dec = 1'(dec); v.e_clr = 1'(tc);
        v.e_mag = 1'(mag);  v.e_beep = 1'(bp); v.e_st = 3'(st);
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [12:0] act;
        logic [12:0] exp;
        @(negedge clk);
        rst = v.rst; start = v.start; stop = v.stop; clear = v.clr;
        door_closed = v.door; key_valid = v.kv; key_digit = v.kd;
        power_level = v.pwr; timer_zero = v.tz; tick_1hz = v.tick;
        @(posedge clk);
        #1;
        act = {timer_load, timer_digit, timer_dec, timer_clear, mag_on, beep, state};
        exp = {v.e_load, v.e_digit, v.e_dec, v.e_clr, v.e_mag, v.e_beep, v.e_st};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d: got ld=%0b dg=%0d dec=%0b clr=%0b mag=%0b beep=%0b st=%0d, expected ld=%0b dg=%0d dec=%0b clr=%0b mag=%0b beep=%0b st=%0d",
                     idx, timer_load, timer_digit, timer_dec, timer_clear, mag_on, beep, state,
                     v.e_load, v.e_digit, v.e_dec, v.e_clr, v.e_mag, v.e_beep, v.e_st);
        end
        if (timer_dec === 1'b1) dec_seen++;
    endtask

    initial begin
        int ph;
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; door_closed = 1'b1;
        key_valid = 1'b0; key_digit = 4'd0; power_level = 4'd10; timer_zero = 1'b0; tick_1hz = 1'b0;

        //                 r s p c d kv kd pw tz tk   ld dg dec tc mag bp state
        tbl.push_back(mk(1,0,0,0,1,0, 0,10,0,0,  0, 0,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1, 1,10,0,0,  1, 1,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,0,0,  0, 1,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1, 3,10,0,0,  1, 3,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1, 0,10,0,0,  1, 0,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,1,0,0,1,1, 7,10,0,0,  0, 0,0,0,1,0,ST_COOK));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,0,1,  0, 0,1,0,1,0,ST_COOK));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,0,0,  0, 0,0,0,1,0,ST_COOK));
        tbl.push_back(mk(0,0,0,0,0,0, 0,10,0,0,  0, 0,0,0,0,0,ST_PAUSE));
        tbl.push_back(mk(0,1,0,0,0,0, 0,10,0,0,  0, 0,0,0,0,0,ST_PAUSE));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,0,0,  0, 0,0,0,0,0,ST_PAUSE));
        tbl.push_back(mk(0,1,0,0,1,0, 0,10,0,0,  0, 0,0,0,1,0,ST_COOK));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,1,0,  0, 0,0,0,0,1,ST_DONE));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,1,1,  0, 0,0,0,0,1,ST_DONE));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,1,1,  0, 0,0,0,0,1,ST_DONE));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,1,0,  0, 0,0,0,0,1,ST_DONE));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,1,1,  0, 0,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,1,0,0,1,0, 0,10,1,0,  0, 0,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1,12,10,0,0,  0, 0,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1, 5,10,0,0,  1, 5,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1, 6,10,0,0,  1, 6,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1, 7,10,0,0,  1, 7,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1, 8,10,0,0,  1, 8,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1, 9,10,0,0,  0, 8,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,0,0,0,1,1, 2,10,0,0,  0, 8,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,1,0,0,1,0, 0,10,0,0,  0, 8,0,0,1,0,ST_COOK));
        tbl.push_back(mk(0,1,0,1,1,0, 0,10,0,0,  0, 8,0,1,0,0,ST_IDLE));
        tbl.push_back(mk(0,1,0,0,1,0, 0,10,0,0,  0, 8,0,0,1,0,ST_COOK));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,1,0,  0, 8,0,0,0,1,ST_DONE));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,1,1,  0, 8,0,0,0,1,ST_DONE));
        tbl.push_back(mk(0,0,1,0,1,0, 0,10,1,0,  0, 8,0,0,0,0,ST_IDLE));
        tbl.push_back(mk(0,1,0,0,1,0, 0,10,0,0,  0, 8,0,0,1,0,ST_COOK));
        tbl.push_back(mk(0,0,1,0,1,0, 0,10,0,0,  0, 8,0,0,0,0,ST_PAUSE));
        tbl.push_back(mk(0,0,1,0,1,0, 0,10,0,0,  0, 8,0,1,0,0,ST_IDLE));
        tbl.push_back(mk(0,1,0,0,1,0, 0,10,0,0,  0, 8,0,0,1,0,ST_COOK));
        tbl.push_back(mk(0,0,0,0,1,0, 0,10,0,1,  0, 8,1,0,1,0,ST_COOK));
        tbl.push_back(mk(1,0,0,0,1,0, 0,10,0,1,  0, 0,0,0,0,0,ST_IDLE));

        foreach (tbl[i]) apply(tbl[i], i);

        // Power 3 over two duty windows: on for phases 0..2 only.
        apply(mk(0,1,0,0,1,0,0,3,0,0, 0,0,0,0,1,0,ST_COOK), 100);
        dec_seen = 0;
        ph = 0;
        for (int k = 1; k <= 20; k++) begin
            ph = (ph + 1) % 10;
            apply(mk(0,0,0,0,1,0,0,3,0,1, 0,0,1,0,int'(ph < 3),0,ST_COOK), 100 + 2 * k);
            apply(mk(0,0,0,0,1,0,0,3,0,0, 0,0,0,0,int'(ph < 3),0,ST_COOK), 101 + 2 * k);
        end
        checks++;
        if (dec_seen != 20) begin
            errors++;
            $display("FAIL dec_count: got %0d pulses, expected 20", dec_seen);
        end

        // Power clamp and live power changes at phase 1.
        apply(mk(0,0,0,0,1,0,0, 0,0,1, 0,0,1,0,1,0,ST_COOK), 200);
        apply(mk(0,0,0,0,1,0,0,11,0,0, 0,0,0,0,1,0,ST_COOK), 201);
        apply(mk(0,0,0,0,1,0,0, 1,0,0, 0,0,0,0,0,0,ST_COOK), 202);
        apply(mk(0,0,0,0,1,0,0, 3,0,0, 0,0,0,0,1,0,ST_COOK), 203);
        // Phase is kept across pause/resume.
        apply(mk(0,0,0,0,1,0,0, 3,0,1, 0,0,1,0,1,0,ST_COOK), 204);
        apply(mk(0,0,0,0,0,0,0, 3,0,0, 0,0,0,0,0,0,ST_PAUSE), 205);
        apply(mk(0,1,0,0,1,0,0, 3,0,0, 0,0,0,0,1,0,ST_COOK), 206);
        apply(mk(0,0,0,0,1,0,0, 3,0,1, 0,0,1,0,0,0,ST_COOK), 207);
        apply(mk(0,0,0,0,0,0,0, 3,0,0, 0,0,0,0,0,0,ST_PAUSE), 208);
        apply(mk(0,1,0,0,1,0,0, 3,0,0, 0,0,0,0,0,0,ST_COOK), 209);
        apply(mk(1,0,0,0,1,0,0, 3,0,0, 0,0,0,0,0,0,ST_IDLE), 210);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
